// File: rtl/risc_pkg.sv
// risc_pkg: shared types for the RV32M multiply/divide sequencer.
//   op_enum_mdu : the eight RV32M operations (bit 2 set = divide family).
//   mdu_state_e : sequencer state encoding; IDLE/CALC/DONE constants below.
//   op_signed_a / op_signed_b : whether an operand is taken as two's complement.
//   op_is_div   : true for DIV, DIVU, REM, REMU.
package risc_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_enum_mdu;

    typedef logic [1:0] mdu_state_e;

    localparam mdu_state_e ST_IDLE = 2'd0;
    localparam mdu_state_e ST_CALC = 2'd1;
    localparam mdu_state_e ST_DONE = 2'd2;

    function automatic logic op_is_div(input op_enum_mdu op);
        return op[2];
    endfunction

    // MULHSU treats rs1 as signed and rs2 as unsigned.
    function automatic logic op_signed_a(input op_enum_mdu op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_signed_b(input op_enum_mdu op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/mdu_divstep.sv
// mdu_divstep: one combinational iteration of restoring division.
//   rem_in  : current partial remainder (XLEN+1 bits)
//   dvd_bit : next dividend bit, shifted in at the LSB
//   divisor : divisor magnitude
//   rem_out : next partial remainder
//   q_bit   : quotient bit produced by this iteration
module mdu_divstep #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_in,
    input  logic            dvd_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_out,
    output logic            q_bit
);

    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] diff;

    always_comb begin
        shifted = {rem_in, dvd_bit};
        diff    = shifted - {2'b00, divisor};
        // A borrow out of the trial subtract means the divisor did not fit:
        // keep (restore) the shifted remainder and emit a 0 quotient bit.
        q_bit   = ~diff[XLEN+1];
        rem_out = q_bit ? diff[XLEN:0] : shifted[XLEN:0];
    end

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV32M multiply/divide sequencer beside the execute ALU.
// Radix-2 shift-add multiply, restoring divide, XLEN iterations per op;
// divide-by-zero and signed overflow complete without iterating.
// Build option: define MDU_DIV_EN to build the divider. Without it the
// divide family returns 0 one cycle after accept.
// Ports:
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   flush           : abort the operation in flight, no response
//   req_valid/ready : request handshake, ready only in IDLE
//   req_op          : operation (op_enum_mdu)
//   req_a, req_b    : rs1, rs2 operands
//   resp_valid      : one-cycle result pulse
//   resp_res        : registered result, held until the next DONE/flush/reset
module mdu_seq
    import risc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  op_enum_mdu      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_res
);

    localparam int            CW       = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LOAD = CW'(XLEN - 1);

    mdu_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    op_enum_mdu        op_q, op_d;
    logic              neg_q, neg_d;      // negate product / quotient
    logic [XLEN-1:0]   mcand_q, mcand_d;  // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] prod_q, prod_d;    // mul: {acc, multiplier}; div: low half dividend->quotient
    logic [XLEN-1:0]   res_q, res_d;

    logic            sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            fast;
    logic [XLEN-1:0] fast_res;

    logic [XLEN-1:0]   addend;
    logic [XLEN:0]     acc_sum;
    logic [2*XLEN-1:0] prod_mul;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   mul_res;

`ifdef MDU_DIV_EN
    logic [XLEN:0]   rem_q, rem_d;
    logic            nrem_q, nrem_d;      // remainder takes the sign of a
    logic [XLEN:0]   rem_nxt;
    logic            q_bit;
    logic [XLEN-1:0] quo_nxt;
    logic [XLEN-1:0] div_res;

    mdu_divstep #(.XLEN(XLEN)) u_divstep (
        .rem_in  (rem_q),
        .dvd_bit (prod_q[XLEN-1]),
        .divisor (mcand_q),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );
`endif

    // Operand sign handling and the non-iterating cases.
    always_comb begin
        sign_a   = op_signed_a(req_op) & req_a[XLEN-1];
        sign_b   = op_signed_b(req_op) & req_b[XLEN-1];
        mag_a    = sign_a ? -req_a : req_a;
        mag_b    = sign_b ? -req_b : req_b;
        fast     = 1'b0;
        fast_res = '0;
`ifdef MDU_DIV_EN
        if (op_is_div(req_op) && req_b == '0) begin
            fast     = 1'b1;
            fast_res = (req_op inside {OP_DIV, OP_DIVU}) ? '1 : req_a;
        end else if ((req_op inside {OP_DIV, OP_REM}) &&
                     req_a == {1'b1, {(XLEN-1){1'b0}}} && req_b == '1) begin
            fast     = 1'b1;
            fast_res = (req_op == OP_DIV) ? req_a : '0;
        end
`else
        fast = op_is_div(req_op);
`endif
    end

    // Datapath for one iteration and the final sign fix-up.
    always_comb begin
        addend   = prod_q[0] ? mcand_q : '0;
        acc_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, addend};
        prod_mul = {acc_sum, prod_q[XLEN-1:1]};
        prod_fix = neg_q ? -prod_mul : prod_mul;
        mul_res  = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
`ifdef MDU_DIV_EN
        quo_nxt  = {prod_q[XLEN-2:0], q_bit};
        if (op_q inside {OP_DIV, OP_DIVU}) begin
            div_res = neg_q ? -quo_nxt : quo_nxt;
        end else begin
            div_res = nrem_q ? -rem_nxt[XLEN-1:0] : rem_nxt[XLEN-1:0];
        end
`endif
    end

    always_comb begin
        // NOTE: every _d starts from its _q so no branch can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        res_d   = res_q;
`ifdef MDU_DIV_EN
        rem_d   = rem_q;
        nrem_d  = nrem_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d  = req_op;
                    neg_d = sign_a ^ sign_b;
                    if (fast) begin
                        state_d = ST_DONE;
                        res_d   = fast_res;
                    end else begin
                        state_d = ST_CALC;
                        cnt_d   = CNT_LOAD;
                        // Multiply iterates over b with a as multiplicand;
                        // divide shifts a out as the dividend over divisor b.
                        mcand_d = op_is_div(req_op) ? mag_b : mag_a;
                        prod_d  = {{XLEN{1'b0}}, op_is_div(req_op) ? mag_a : mag_b};
`ifdef MDU_DIV_EN
                        rem_d   = '0;
                        nrem_d  = sign_a;
`endif
                    end
                end
            end
            ST_CALC: begin
                cnt_d = cnt_q - CW'(1);
`ifdef MDU_DIV_EN
                if (op_is_div(op_q)) begin
                    prod_d = {{XLEN{1'b0}}, quo_nxt};
                    rem_d  = rem_nxt;
                end else begin
                    prod_d = prod_mul;
                end
`else
                prod_d = prod_mul;
`endif
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
`ifdef MDU_DIV_EN
                    res_d   = op_is_div(op_q) ? div_res : mul_res;
`else
                    res_d   = mul_res;
`endif
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            prod_d  = '0;
            res_d   = '0;
`ifdef MDU_DIV_EN
            rem_d   = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge value of every other flop.
        if (rst) begin
            // NOTE: datapath registers are reset as well, since reset must
            // leave resp_res at zero, not just the control state.
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MUL;
            neg_q   <= 1'b0;
            mcand_q <= '0;
            prod_q  <= '0;
            res_q   <= '0;
`ifdef MDU_DIV_EN
            rem_q   <= '0;
            nrem_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            res_q   <= res_d;
`ifdef MDU_DIV_EN
            rem_q   <= rem_d;
            nrem_q  <= nrem_d;
`endif
        end
    end

    // A flush or reset landing on the DONE cycle swallows the pulse.
    assign resp_valid = (state_q == ST_DONE) & ~flush & ~rst;
    assign req_ready  = (state_q == ST_IDLE);
    assign resp_res   = res_q;

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: self-checking bench for mdu_seq. A vector table drives single
// operations; expected results go into a scoreboard queue on accept and are
// popped when resp_valid fires. Hand sequences cover flush, flush on the DONE
// cycle, and reset in mid-operation. Expectations follow MDU_DIV_EN.
module tb_mdu_seq;
    import risc_pkg::*;

`ifdef MDU_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    op_enum_mdu  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic [31:0] resp_res;

    mdu_seq #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_res   (resp_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        op_enum_mdu  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        bit          noise;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    // Reference model built on 64-bit arithmetic of sign/zero-extended operands.
    function automatic logic [31:0] ref_res(input op_enum_mdu op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = (op inside {OP_MUL, OP_MULH, OP_MULHSU}) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (op inside {OP_MUL, OP_MULH}) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        case (op)
            OP_MUL:                       return p[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: return p[63:32];
            default: begin
                if (!DIV_ON) return 32'h0;
                if (b == 32'h0) return (op inside {OP_DIV, OP_DIVU}) ? 32'hFFFF_FFFF : a;
                if ((op inside {OP_DIV, OP_REM}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return (op == OP_DIV) ? 32'h8000_0000 : 32'h0;
                case (op)
                    OP_DIV:  return $signed(a) / $signed(b);
                    OP_DIVU: return a / b;
                    OP_REM:  return $signed(a) % $signed(b);
                    default: return a % b;
                endcase
            end
        endcase
    endfunction

    function automatic int ref_lat(input op_enum_mdu op, input logic [31:0] a, input logic [31:0] b);
        if (!op_is_div(op)) return 33;
        if (!DIV_ON) return 1;
        if (b == 32'h0) return 1;
        if ((op inside {OP_DIV, OP_REM}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic void add_vec(input string name, input op_enum_mdu op, input logic [31:0] a,
                                    input logic [31:0] b, input logic [31:0] exp, input int lat,
                                    input bit noise);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat; v.noise = noise;
        vecs.push_back(v);
    endfunction

    // Issue one operation, then watch for its response cycle by cycle.
    task automatic run_op(input vec_t v);
        exp_t e;
        int   waited;
        int   resp_cyc;
        bit   got;
        bit   busy_ok;
        waited = 0;
        while (!req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check({v.name, "_idle"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = v.op;
        req_a     = v.a;
        req_b     = v.b;
        @(posedge clk);
        e.res = v.exp;
        e.lat = v.lat;
        sb.push_back(e);
        got      = 1'b0;
        busy_ok  = 1'b1;
        resp_cyc = 0;
        for (int n = 1; n <= 40 && !got; n++) begin
            @(negedge clk);
            if (v.noise && n <= 5) begin
                // Requests while busy must be ignored.
                req_valid = 1'b1;
                req_op    = OP_MULHU;
                req_a     = $urandom;
                req_b     = $urandom;
            end else begin
                req_valid = 1'b0;
            end
            if (req_ready) busy_ok = 1'b0;
            if (resp_valid) begin
                got      = 1'b1;
                resp_cyc = n;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check({v.name, "_res"}, resp_res, e.res);
                    check({v.name, "_cycle"}, 32'(resp_cyc), 32'(e.lat));
                end else begin
                    check({v.name, "_sb_empty"}, 32'(sb.size()), 32'd1);
                end
            end
        end
        req_valid = 1'b0;
        check({v.name, "_resp_seen"}, {31'b0, got}, 32'd1);
        check({v.name, "_busy_not_ready"}, {31'b0, busy_ok}, 32'd1);
        @(negedge clk);
        check({v.name, "_ready_after"}, {31'b0, req_ready}, 32'd1);
        check({v.name, "_single_pulse"}, {31'b0, resp_valid}, 32'd0);
        check({v.name, "_hold"}, resp_res, v.exp);
    endtask

    task automatic start_op(input op_enum_mdu op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        @(negedge clk);      // cycle 1
        req_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        v;
        op_enum_mdu  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_op    = OP_MUL;
        req_a     = '0;
        req_b     = '0;

        add_vec("mul_7x6",    OP_MUL,    32'd7,          32'd6,          32'd42,        33, 1'b1);
        add_vec("mulh_m1",    OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 33, 1'b0);
        add_vec("mulhu_m1",   OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 33, 1'b0);
        add_vec("mulhsu_m1",  OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 33, 1'b0);
        add_vec("mulh_min",   OP_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 33, 1'b0);
        add_vec("mul_neg",    OP_MUL,    32'hFFFF_FFF9,  32'd6,          32'hFFFF_FFD6, 33, 1'b0);
        add_vec("div_m7_2",   OP_DIV,    32'hFFFF_FFF9,  32'd2,  DIV_ON ? 32'hFFFF_FFFD : 32'h0, DIV_ON ? 33 : 1, 1'b0);
        add_vec("rem_m7_2",   OP_REM,    32'hFFFF_FFF9,  32'd2,  DIV_ON ? 32'hFFFF_FFFF : 32'h0, DIV_ON ? 33 : 1, 1'b0);
        add_vec("divu_by0",   OP_DIVU,   32'd5,          32'd0,  DIV_ON ? 32'hFFFF_FFFF : 32'h0, 1, 1'b0);
        add_vec("remu_by0",   OP_REMU,   32'd5,          32'd0,  DIV_ON ? 32'd5 : 32'h0,         1, 1'b0);
        add_vec("div_ovf",    OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, DIV_ON ? 32'h8000_0000 : 32'h0, 1, 1'b0);
        add_vec("rem_ovf",    OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0, 1, 1'b0);
        add_vec("div_10_2",   OP_DIV,    32'd10,         32'd2,  DIV_ON ? 32'd5 : 32'h0, DIV_ON ? 33 : 1, 1'b0);
        add_vec("remu_100_7", OP_REMU,   32'd100,        32'd7,  DIV_ON ? 32'd2 : 32'h0, DIV_ON ? 33 : 1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            rop = op_enum_mdu'(3'($urandom_range(0, 7)));
            ra  = $urandom;
            rb  = (i == 3) ? 32'h0 : $urandom;
            add_vec($sformatf("rand%0d", i), rop, ra, rb, ref_res(rop, ra, rb), ref_lat(rop, ra, rb), 1'b0);
        end

        // Reset state.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", {31'b0, req_ready}, 32'd1);
        check("reset_valid", {31'b0, resp_valid}, 32'd0);
        check("reset_res", resp_res, 32'h0);

        foreach (vecs[i]) begin
            v = vecs[i];
            run_op(v);
        end

        // Reset in the middle of an iterating op.
        v.name = "mul_pre"; v.op = OP_MUL; v.a = 32'd11; v.b = 32'd13;
        v.exp = 32'd143; v.lat = 33; v.noise = 1'b0;
        run_op(v);
        start_op(DIV_ON ? OP_DIV : OP_MUL, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
        check("rst_mid_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_mid_res", resp_res, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Flush in cycle 10 of a MUL, then back-to-back MUL 3x3.
        start_op(OP_MUL, 32'd100, 32'd3);
        for (int n = 2; n <= 10; n++) @(negedge clk);
        flush = 1'b1;
        check("flush_c10_valid", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        check("flush_c11_ready", {31'b0, req_ready}, 32'd1);
        check("flush_c11_valid", {31'b0, resp_valid}, 32'd0);
        check("flush_c11_res", resp_res, 32'h0);
        flush = 1'b0;
        v.name = "mul_3x3"; v.op = OP_MUL; v.a = 32'd3; v.b = 32'd3;
        v.exp = 32'd9; v.lat = 33; v.noise = 1'b0;
        run_op(v);

        // Flush on the DONE cycle suppresses the pulse and clears the result.
        start_op(OP_MUL, 32'd5, 32'd5);
        for (int n = 2; n <= 32; n++) @(negedge clk);
        @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush_done_valid", {31'b0, resp_valid}, 32'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_done_ready", {31'b0, req_ready}, 32'd1);
        check("flush_done_res", resp_res, 32'h0);
        check("flush_done_no_late", {31'b0, resp_valid}, 32'd0);

        v.name = "mul_after"; v.op = OP_MULHU; v.a = 32'h8000_0000; v.b = 32'd4;
        v.exp = 32'd2; v.lat = 33; v.noise = 1'b0;
        run_op(v);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
